// File: rtl/ih_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Package     : ih_pkg                                                        |
// | Description : Shared types, instruction field positions, status bit indices |
// |               and helpers for the instruction handler.                      |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
package ih_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CONFIG_OK = 3'd1,
        S_LOAD      = 3'd2,
        S_READY     = 3'd3,
        S_RUN       = 3'd4
    } ih_state_e;

    typedef struct packed {
        logic       mode;
        logic       debug;
        logic [8:0] width;
        logic [8:0] height;
        logic [2:0] n_simd;
        logic [7:0] scale;
    } ih_cfg_t;

    // Instruction field bit positions
    localparam int c_bit_cmd    = 31;
    localparam int c_bit_mode   = 30;
    localparam int c_bit_debug  = 29;
    localparam int c_width_msb  = 28;
    localparam int c_width_lsb  = 20;
    localparam int c_height_msb = 19;
    localparam int c_height_lsb = 11;
    localparam int c_simd_msb   = 10;
    localparam int c_simd_lsb   = 8;
    localparam int c_scale_msb  = 7;
    localparam int c_scale_lsb  = 0;
    // A command whose dimension fields are all zero is START
    localparam int c_start_msb  = 28;
    localparam int c_start_lsb  = 11;

    // status bit indices
    localparam int c_st_cfg  = 0;
    localparam int c_st_load = 1;
    localparam int c_st_run  = 2;
    localparam int c_st_err  = 3;

    function automatic ih_cfg_t decode_cfg(input logic [31:0] instr);
        ih_cfg_t c;
        c.mode   = instr[c_bit_mode];
        c.debug  = instr[c_bit_debug];
        c.width  = instr[c_width_msb:c_width_lsb];
        c.height = instr[c_height_msb:c_height_lsb];
        c.n_simd = instr[c_simd_msb:c_simd_lsb];
        c.scale  = instr[c_scale_msb:c_scale_lsb];
        return c;
    endfunction

    // Enable mask covering the lowest n_bytes byte lanes of a 32-bit word
    function automatic logic [3:0] low_byte_mask(input logic [2:0] n_bytes);
        logic [3:0] m;
        case (n_bytes)
            3'd0:    m = 4'b0000;
            3'd1:    m = 4'b0001;
            3'd2:    m = 4'b0011;
            3'd3:    m = 4'b0111;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/param_instruction_handler_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Interface   : param_instruction_handler_if                                  |
// | Description : Host request/response and image-memory bus of the handler.    |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
interface param_instruction_handler_if #(
    parameter int ADDR_W = 16
);
    logic [1:0]        ir_in;
    logic [31:0]       instruction;
    logic [31:0]       response_data;
    logic              response_valid;
    logic              o_mem_we;
    logic [3:0]        o_mem_byte_en;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [31:0]       o_mem_wdata;
    logic [31:0]       i_mem_rdata;

    // Host and memory side
    modport master (
        output ir_in, instruction, i_mem_rdata,
        input  response_data, response_valid,
        input  o_mem_we, o_mem_byte_en, o_mem_addr, o_mem_wdata
    );

    // Handler side
    modport slave (
        input  ir_in, instruction, i_mem_rdata,
        output response_data, response_valid,
        output o_mem_we, o_mem_byte_en, o_mem_addr, o_mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/strobe_edge.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : strobe_edge                                                   |
// | Description : Rising-edge detector for the two host strobes, with a         |
// |               one-deep pending flag deferring a readback that coincides     |
// |               with a command edge.                                          |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module strobe_edge (
    input  wire        clk,
    input  wire        rst,
    input  wire  [1:0] i_ir,
    output logic       o_cmd_edge,
    output logic       o_rd_now,
    output logic       o_rd_defer,
    output logic       o_rd_pend
);
    logic [1:0] r_ir_q;
    logic       r_pend;
    logic [1:0] w_edge;

    assign w_edge     = i_ir & ~r_ir_q;
    assign o_cmd_edge = w_edge[0];
    assign o_rd_now   = w_edge[1] & ~w_edge[0];
    assign o_rd_defer = w_edge[1] &  w_edge[0];
    assign o_rd_pend  = r_pend;

    // Strobe history and the deferred-readback flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ir_q <= 2'b00;
            r_pend <= 1'b0;
        end else begin
            r_ir_q <= i_ir;
            r_pend <= o_rd_defer;
        end
    end
endmodule
`default_nettype wire

// File: rtl/param_instruction_handler.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : param_instruction_handler                                     |
// | Description : Host instruction front end: decodes commands, latches config, |
// |               streams pixel words to memory, gates start, serves readback.  |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module param_instruction_handler
    import ih_pkg::*;
#(
    parameter int PIX_W     = 8,
    parameter int ADDR_W    = 16,
    parameter int BASE_ADDR = 0,
    parameter int MAX_W     = 511,
    parameter int MAX_H     = 511
) (
    input  wire                         clk,
    input  wire                         reset,
    param_instruction_handler_if.slave  bus,
    output logic                        i_mode_select,
    output logic                        debug_mode,
    output logic [8:0]                  img_width,
    output logic [8:0]                  img_height,
    output logic [2:0]                  N_simd,
    output logic [7:0]                  scale_factor,
    output logic                        start,
    input  wire                         done,
    output logic [3:0]                  status
);
    localparam int                c_ppw      = 32 / PIX_W;
    localparam int                c_ppw_log2 = (PIX_W == 16) ? 1 : 2;
    localparam int                c_bpp      = PIX_W / 8;
    localparam logic [9:0]        c_max_w    = 10'(MAX_W);
    localparam logic [9:0]        c_max_h    = 10'(MAX_H);
    localparam logic [ADDR_W-1:0] c_base     = ADDR_W'(BASE_ADDR);

    ih_state_e         r_state, w_state_next;
    ih_cfg_t           r_cfg;
    ih_cfg_t           w_cfg_new;
    logic [17:0]       r_idx;
    logic              r_error;
    logic              r_mem_we;
    logic [3:0]        r_mem_be;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic [31:0]       r_resp_data;
    logic              r_resp_valid;
    logic              r_rd_inflight;
    logic [ADDR_W-1:0] r_pend_addr;

    logic              w_cmd_edge, w_rd_now, w_rd_defer, w_rd_pend, w_rd_req;
    logic              w_is_start, w_cfg_valid, w_last;
    logic              w_do_write, w_do_cfg, w_do_read, w_set_err;
    logic [17:0]       w_total, w_words;
    logic [1:0]        w_rem;
    logic [2:0]        w_rem_bytes;
    logic [3:0]        w_be;
    logic [ADDR_W-1:0] w_rd_addr;

    strobe_edge u_strobe_edge (
        .clk        (clk),
        .rst        (reset),
        .i_ir       (bus.ir_in),
        .o_cmd_edge (w_cmd_edge),
        .o_rd_now   (w_rd_now),
        .o_rd_defer (w_rd_defer),
        .o_rd_pend  (w_rd_pend)
    );

    assign w_rd_req  = w_rd_now | w_rd_pend;
    assign w_rd_addr = w_rd_pend ? r_pend_addr : bus.instruction[ADDR_W-1:0];

    // Command field decode
    assign w_cfg_new   = decode_cfg(bus.instruction);
    assign w_is_start  = (bus.instruction[c_start_msb:c_start_lsb] == '0);
    assign w_cfg_valid = (w_cfg_new.width  != 9'd0) && ({1'b0, w_cfg_new.width}  <= c_max_w) &&
                         (w_cfg_new.height != 9'd0) && ({1'b0, w_cfg_new.height} <= c_max_h) &&
                         (w_cfg_new.n_simd != 3'd0) && (w_cfg_new.scale != 8'd0);

    // Load geometry from the latched configuration
    assign w_total     = {9'd0, r_cfg.width} * {9'd0, r_cfg.height};
    assign w_words     = (w_total + 18'(c_ppw - 1)) >> c_ppw_log2;
    assign w_rem       = w_total[1:0] & 2'(c_ppw - 1);
    assign w_rem_bytes = 3'(32'(w_rem) * c_bpp);
    assign w_last      = (r_idx == w_words - 18'd1);
    assign w_be        = (w_last && (w_rem != 2'd0)) ? low_byte_mask(w_rem_bytes) : 4'hF;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and action decode; LOAD treats every word as pixel data
    always_comb begin
        w_state_next = r_state;
        w_do_write   = 1'b0;
        w_do_cfg     = 1'b0;
        w_do_read    = 1'b0;
        w_set_err    = 1'b0;
        if (w_cmd_edge) begin
            if ((r_state == S_LOAD) ||
                ((r_state == S_CONFIG_OK) && !bus.instruction[c_bit_cmd])) begin
                w_do_write   = 1'b1;
                w_state_next = w_last ? S_READY : S_LOAD;
            end else if (!bus.instruction[c_bit_cmd]) begin
                w_set_err = 1'b1;
            end else if (w_is_start) begin
                if (r_state == S_READY) begin
                    w_state_next = S_RUN;
                end else begin
                    w_set_err = 1'b1;
                end
            end else if (w_cfg_valid && (r_state != S_RUN)) begin
                w_do_cfg     = 1'b1;
                w_state_next = S_CONFIG_OK;
            end else begin
                w_set_err = 1'b1;
            end
        end
        if ((r_state == S_RUN) && done) begin
            w_state_next = S_READY;
        end
        if (w_rd_req && !w_cmd_edge) begin
            if (r_state == S_LOAD) begin
                w_set_err = 1'b1;
            end else begin
                w_do_read = 1'b1;
            end
        end
    end

    // Config, counters, memory port and readback response
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cfg         <= '0;
            r_idx         <= '0;
            r_error       <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_be      <= 4'h0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_resp_data   <= '0;
            r_resp_valid  <= 1'b0;
            r_rd_inflight <= 1'b0;
            r_pend_addr   <= '0;
        end else begin
            r_mem_we      <= 1'b0;
            r_mem_be      <= 4'h0;
            r_resp_valid  <= 1'b0;
            r_rd_inflight <= w_do_read;
            if (w_do_cfg) begin
                r_cfg <= w_cfg_new;
                r_idx <= '0;
            end
            if (w_set_err) begin
                r_error <= 1'b1;
            end else if (w_do_cfg) begin
                r_error <= 1'b0;
            end
            if (w_do_write) begin
                r_mem_we    <= 1'b1;
                r_mem_be    <= w_be;
                r_mem_addr  <= c_base + ADDR_W'(r_idx);
                r_mem_wdata <= bus.instruction;
                r_idx       <= r_idx + 18'd1;
            end else if (w_do_read) begin
                r_mem_addr <= w_rd_addr;
            end
            if (w_rd_defer) begin
                r_pend_addr <= bus.instruction[ADDR_W-1:0];
            end
            if (r_rd_inflight) begin
                r_resp_data  <= bus.i_mem_rdata;
                r_resp_valid <= 1'b1;
            end
        end
    end

    assign bus.o_mem_we       = r_mem_we;
    assign bus.o_mem_byte_en  = r_mem_be;
    assign bus.o_mem_addr     = r_mem_addr;
    assign bus.o_mem_wdata    = r_mem_wdata;
    assign bus.response_data  = r_resp_data;
    assign bus.response_valid = r_resp_valid;

    assign i_mode_select = r_cfg.mode;
    assign debug_mode    = r_cfg.debug;
    assign img_width     = r_cfg.width;
    assign img_height    = r_cfg.height;
    assign N_simd        = r_cfg.n_simd;
    assign scale_factor  = r_cfg.scale;
    assign start         = (r_state == S_RUN);

    assign status[c_st_cfg]  = (r_state != S_IDLE);
    assign status[c_st_load] = (r_state == S_READY) || (r_state == S_RUN);
    assign status[c_st_run]  = (r_state == S_RUN);
    assign status[c_st_err]  = r_error;
endmodule
`default_nettype wire

// File: tb/tb_param_instruction_handler.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : tb_param_instruction_handler                                  |
// | Description : Directed self-checking bench; 8-bit and 16-bit pixel          |
// |               instances share one host stimulus stream.                     |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module tb_param_instruction_handler;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  ir = 2'b00;
    logic [31:0] instr = '0;
    logic        done = 1'b0;
    logic        rd_override = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    logic       mode8, debug8, start8, mode16, debug16, start16;
    logic [8:0] width8, height8, width16, height16;
    logic [2:0] nsimd8, nsimd16;
    logic [7:0] scale8, scale16;
    logic [3:0] status8, status16;

    int         wr8, bad_addr8, bad_data8, nonf8, resp8;
    logic [3:0] last_be8;
    int         wr16, bad_addr16, nonf16, resp16;
    logic [3:0] last_be16;

    logic [31:0] bad_cfg [4];

    always #5 clk = ~clk;

    param_instruction_handler_if #(.ADDR_W(16)) bus8 ();
    param_instruction_handler_if #(.ADDR_W(16)) bus16 ();

    assign bus8.ir_in        = ir;
    assign bus8.instruction  = instr;
    assign bus8.i_mem_rdata  = rd_override ? 32'hDEADBEEF : {16'hA5A5, bus8.o_mem_addr};
    assign bus16.ir_in       = ir;
    assign bus16.instruction = instr;
    assign bus16.i_mem_rdata = rd_override ? 32'hDEADBEEF : {16'hA5A5, bus16.o_mem_addr};

    param_instruction_handler #(.PIX_W(8), .ADDR_W(16), .BASE_ADDR(0), .MAX_W(511), .MAX_H(511)) u_dut8 (
        .clk(clk), .reset(reset), .bus(bus8),
        .i_mode_select(mode8), .debug_mode(debug8), .img_width(width8), .img_height(height8),
        .N_simd(nsimd8), .scale_factor(scale8), .start(start8), .done(done), .status(status8)
    );

    param_instruction_handler #(.PIX_W(16), .ADDR_W(16), .BASE_ADDR(0), .MAX_W(511), .MAX_H(511)) u_dut16 (
        .clk(clk), .reset(reset), .bus(bus16),
        .i_mode_select(mode16), .debug_mode(debug16), .img_width(width16), .img_height(height16),
        .N_simd(nsimd16), .scale_factor(scale16), .start(start16), .done(done), .status(status16)
    );

    function automatic logic [31:0] pattern(input int i);
        return 32'h0BAD_0000 | 32'(i);
    endfunction

    function automatic logic [31:0] mk_cfg(input logic m, input logic d, input logic [8:0] w,
                                           input logic [8:0] h, input logic [2:0] n, input logic [7:0] s);
        return {1'b1, m, d, w, h, n, s};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One-cycle strobe; returns in the cycle where the action is visible
    task automatic send(input logic [1:0] bits, input logic [31:0] word);
        @(negedge clk);
        ir    = bits;
        instr = word;
        @(negedge clk);
        ir = 2'b00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    // Write/response monitors; expected address is the running write index from BASE_ADDR=0
    always @(negedge clk) begin
        if (reset) begin
            wr8 = 0; bad_addr8 = 0; bad_data8 = 0; nonf8 = 0; resp8 = 0; last_be8 = 4'h0;
            wr16 = 0; bad_addr16 = 0; nonf16 = 0; resp16 = 0; last_be16 = 4'h0;
        end else begin
            if (bus8.o_mem_we) begin
                if (bus8.o_mem_addr !== 16'(wr8)) bad_addr8++;
                if (bus8.o_mem_wdata !== pattern(wr8)) bad_data8++;
                if (bus8.o_mem_byte_en !== 4'hF) nonf8++;
                last_be8 = bus8.o_mem_byte_en;
                wr8++;
            end
            if (bus8.response_valid) resp8++;
            if (bus16.o_mem_we) begin
                if (bus16.o_mem_addr !== 16'(wr16)) bad_addr16++;
                if (bus16.o_mem_byte_en !== 4'hF) nonf16++;
                last_be16 = bus16.o_mem_byte_en;
                wr16++;
            end
            if (bus16.response_valid) resp16++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bad_cfg[0] = mk_cfg(1'b1, 1'b0, 9'd0,  9'd32, 3'd2, 8'd3);
        bad_cfg[1] = mk_cfg(1'b1, 1'b0, 9'd64, 9'd0,  3'd2, 8'd3);
        bad_cfg[2] = mk_cfg(1'b1, 1'b0, 9'd64, 9'd32, 3'd0, 8'd3);
        bad_cfg[3] = mk_cfg(1'b1, 1'b0, 9'd64, 9'd32, 3'd2, 8'd0);

        do_reset();
        check_eq("rst_status", 32'(status8), 32'h0);
        check_eq("rst_cfg", {mode8, debug8, width8, height8, nsimd8, scale8}, 32'h0);
        check_eq("rst_mem", {bus8.o_mem_we, bus8.o_mem_byte_en, bus8.o_mem_addr}, 32'h0);
        check_eq("rst_wdata", bus8.o_mem_wdata, 32'h0);
        check_eq("rst_resp", {bus8.response_valid, start8}, 32'h0);

        // Rejected configs
        foreach (bad_cfg[i]) begin
            send(2'b01, bad_cfg[i]);
            check_eq("bad_cfg_status", 32'(status8), 32'h8);
            check_eq("bad_cfg_width", 32'(width8), 32'h0);
        end

        // Reference config
        send(2'b01, 32'b1_1_0_001000000_000100000_010_00000011);
        check_eq("cfg_fields", {mode8, debug8, width8, height8, nsimd8, scale8},
                 {1'b0, 1'b1, 1'b0, 9'd64, 9'd32, 3'd2, 8'd3});
        check_eq("cfg_status", 32'(status8), 32'h1);

        // START before load
        send(2'b01, 32'h8000_0000);
        check_eq("early_start_status", 32'(status8), 32'h9);
        check_eq("early_start_start", 32'(start8), 32'h0);
        check_eq("early_start_width", 32'(width8), 32'd64);

        // Full 64x32 load
        send(2'b01, 32'b1_1_0_001000000_000100000_010_00000011);
        check_eq("recfg_status", 32'(status8), 32'h1);
        for (int i = 0; i < 512; i++) send(2'b01, pattern(i));
        repeat (2) @(negedge clk);
        #1;
        check_eq("load_count", 32'(wr8), 32'd512);
        check_eq("load_addr", 32'(bad_addr8), 32'd0);
        check_eq("load_data", 32'(bad_data8), 32'd0);
        check_eq("load_be", 32'(nonf8), 32'd0);
        check_eq("load_status", 32'(status8), 32'h3);

        send(2'b01, 32'h8000_0000);
        check_eq("start_hi", 32'(start8), 32'h1);
        check_eq("run_status", 32'(status8), 32'h7);
        @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        check_eq("start_lo", 32'(start8), 32'h0);
        check_eq("done_status", 32'(status8), 32'h3);

        // Solo readback
        send(2'b10, 32'h0000_0042);
        check_eq("rd_addr", {bus8.o_mem_we, 15'd0, bus8.o_mem_addr}, 32'h0000_0042);
        check_eq("rd_valid_n1", 32'(bus8.response_valid), 32'h0);
        @(negedge clk);
        check_eq("rd_valid_n2", 32'(bus8.response_valid), 32'h1);
        check_eq("rd_data", bus8.response_data, 32'hA5A5_0042);
        @(negedge clk);
        check_eq("rd_valid_drop", 32'(bus8.response_valid), 32'h0);

        // 3x3 partial last word, coincident strobes on the 8-bit last word
        do_reset();
        send(2'b01, mk_cfg(1'b0, 1'b0, 9'd3, 9'd3, 3'd1, 8'd1));
        send(2'b01, pattern(0));
        send(2'b01, pattern(1));
        rd_override = 1'b1;
        send(2'b11, pattern(2));
        check_eq("co_write", {bus8.o_mem_we, bus8.o_mem_byte_en, bus8.o_mem_addr}, {11'd0, 1'b1, 4'b0001, 16'd2});
        check_eq("co_valid_n1", 32'(bus8.response_valid), 32'h0);
        @(negedge clk);
        check_eq("co_rd_addr", {bus8.o_mem_we, 15'd0, bus8.o_mem_addr}, 32'h0000_0002);
        check_eq("co_valid_n2", 32'(bus8.response_valid), 32'h0);
        @(negedge clk);
        check_eq("co_valid_n3", 32'(bus8.response_valid), 32'h1);
        check_eq("co_data", bus8.response_data, 32'hDEADBEEF);
        rd_override = 1'b0;
        check_eq("co_status", 32'(status8), 32'h3);
        send(2'b01, pattern(3));
        send(2'b01, pattern(4));
        repeat (2) @(negedge clk);
        #1;
        check_eq("p8_count", 32'(wr8), 32'd3);
        check_eq("p8_last_be", 32'(last_be8), 32'b0001);
        check_eq("p8_partial", 32'(nonf8), 32'd1);
        check_eq("p8_addr", 32'(bad_addr8), 32'd0);
        check_eq("p8_resp", 32'(resp8), 32'd1);
        check_eq("p16_count", 32'(wr16), 32'd5);
        check_eq("p16_last_be", 32'(last_be16), 32'b0011);
        check_eq("p16_partial", 32'(nonf16), 32'd1);
        check_eq("p16_addr", 32'(bad_addr16), 32'd0);
        check_eq("p16_resp", 32'(resp16), 32'd0);
        check_eq("p16_status", 32'(status16), 32'hB);

        // Reset in the middle of a load
        do_reset();
        send(2'b01, mk_cfg(1'b1, 1'b0, 9'd64, 9'd32, 3'd2, 8'd3));
        for (int i = 0; i < 100; i++) send(2'b01, pattern(i));
        send(2'b10, 32'h0000_0010);
        repeat (3) @(negedge clk);
        check_eq("ld_rd_status", 32'(status8), 32'h9);
        check_eq("ld_rd_resp", 32'(resp8), 32'd0);
        do_reset();
        check_eq("mid_rst_status", 32'(status8), 32'h0);
        check_eq("mid_rst_cfg", {mode8, debug8, width8, height8, nsimd8, scale8}, 32'h0);
        check_eq("mid_rst_mem", {bus8.o_mem_we, bus8.o_mem_byte_en, bus8.o_mem_addr}, 32'h0);
        check_eq("mid_rst_out", {bus8.o_mem_wdata[15:0], bus8.response_data[14:0], bus8.response_valid}, 32'h0);
        send(2'b01, pattern(100));
        check_eq("idle_data_we", 32'(bus8.o_mem_we), 32'h0);
        check_eq("idle_data_status", 32'(status8), 32'h8);
        send(2'b01, mk_cfg(1'b1, 1'b0, 9'd64, 9'd32, 3'd2, 8'd3));
        send(2'b01, pattern(0));
        check_eq("restart_write", {bus8.o_mem_we, bus8.o_mem_byte_en, bus8.o_mem_addr}, {11'd0, 1'b1, 4'hF, 16'd0});
        check_eq("restart_wdata", bus8.o_mem_wdata, pattern(0));
        @(negedge clk);
        check_eq("restart_we_drop", 32'(bus8.o_mem_we), 32'h0);
        #1;
        check_eq("restart_count", 32'(wr8), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/param_instruction_handler.md
# param_instruction_handler

Parametrised host-instruction front end for the downscaling core. Decodes 32-bit instructions strobed on two request lines, latches image/processing configuration, streams packed pixel words into image memory with correct partial-word byte enables, gates the core's `start`, and serves memory readback to the host. It generalises pixel width, memory geometry and dimension limits, and adds range checking, status reporting and a read-response handshake.

## Interface
- `PIX_W`, 8, pixel width in bits; legal values 8 or 16
- `ADDR_W`, 16, memory word-address width
- `BASE_ADDR`, 0, word address of pixel 0
- `MAX_W`, 511, largest accepted `img_width`
- `MAX_H`, 511, largest accepted `img_height`
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `ir_in`  in  2  request strobes; [0] = command/data word, [1] = readback; synchronous to `clk`, each held ≥1 cycle
- `instruction`  in  32  instruction word, stable while a strobe is high
- `i_mode_select`, `debug_mode`  out  1 each  config flags
- `img_width`, `img_height`  out  9 each  image dimensions
- `N_simd`  out  3  SIMD lane count
- `scale_factor`  out  8  downscale factor
- `i_mem_rdata`  in  32  memory read data, valid 1 cycle after address
- `o_mem_we`  out  1  write strobe
- `o_mem_byte_en`  out  4  byte enables
- `o_mem_addr`  out  ADDR_W  word address
- `o_mem_wdata`  out  32  write data
- `response_data`  out  32  readback data
- `response_valid`  out  1  one-cycle pulse qualifying `response_data`
- `start`  out  1  held high while the core runs
- `done`  in  1  core completion pulse
- `status`  out  4  {error, running, loaded, configured}

## Operation
- Only strobe rising edges act: `ir_in` is registered, and an edge is `ir_in & ~ir_q`. A held strobe therefore causes exactly one action.
- States:
  - IDLE → CONFIG_OK on a valid config.
  - CONFIG_OK → LOAD on the first data word.
  - LOAD → READY after the last word.
  - READY → RUN on START.
  - RUN → READY on `done`.
- Command decode on an `ir_in[0]` edge, outside LOAD:
  - bit31=0: ignored. Sets `error`, except in CONFIG_OK, where it is pixel data.
  - bit31=1 with bits[28:11]=0: START.
  - bit31=1 with bits[28:11]≠0: CONFIG.
- CONFIG fields: [30] `i_mode_select`, [29] `debug_mode`, [28:20] width, [19:11] height, [10:8] `N_simd`, [7:0] `scale_factor`.
- A CONFIG is rejected (outputs unchanged, `error` set) when any of these holds:
  - width = 0, width > `MAX_W`, height = 0 or height > `MAX_H`
  - `N_simd` = 0
  - `scale_factor` = 0
- An accepted CONFIG is legal in IDLE/CONFIG_OK/READY. It clears `error` and the word counter. In RUN it is rejected.
- Pixel load geometry:
  - PPW = 32/`PIX_W` pixels per word.
  - total = width×height (18 bits).
  - words = ceil(total/PPW).
- Each data edge writes `instruction` to `BASE_ADDR` + idx, then increments idx.
- Byte enables: 4'b1111 on every word except the last. On the last word, rem = total mod PPW; if rem≠0, only the lowest rem×(`PIX_W`/8) bytes are enabled.
- In LOAD, bit31 is data and no commands are decoded. Reconfiguration requires finishing the load or asserting `reset`.
- START in READY raises `start`. START in any other state sets `error` and has no effect.
- `done` outside RUN is ignored.
- Readback on an `ir_in[1]` edge, any state except LOAD:
  - `o_mem_addr` = instruction[ADDR_W-1:0], with `o_mem_we`=0.
  - The cycle after, `response_data` ← `i_mem_rdata` and `response_valid` pulses.
- Readback during LOAD sets `error` and returns no response.
- When `ir_in[0]` and `ir_in[1]` edges coincide, [0] is serviced and [1] is held pending and serviced the next cycle. At most one pending request.

## Timing
- Edge registered at posedge N. Write outputs (`o_mem_we`=1, addr, data, byte_en) are valid for exactly cycle N+1.
- Config outputs update at N+1.
- Readback: address at N+1; `response_valid` at N+2.
- `start` rises at N+1 after START and falls the cycle after `done` is sampled.
- On `reset`:
  - State IDLE; all config outputs 0.
  - `o_mem_we`=0, `o_mem_byte_en`=0, `o_mem_addr`=0, `o_mem_wdata`=0.
  - `response_data`=0, `response_valid`=0, `start`=0, `status`=0.
  - Pending request cleared.
  - Reset mid-LOAD abandons the load; no further writes occur.

## Structure
- Package `ih_pkg` holds:
  - state enum
  - config struct: mode, debug, width, height, N_simd, scale
  - instruction field bit positions
  - `status` bit indices
- Sub-module `strobe_edge`: 2-bit registered rising-edge detector plus the one-deep pending flag for `ir_in[1]`.
- Remaining logic stays in the top module: decode, FSM, counters, byte-enable generation.

## Test plan
- CONFIG 32'b1_1_0_001000000_000100000_010_00000011 → outputs mode=1, debug=0, width=64, height=32, N_simd=2, scale=3; `status`=4'b0001.
- 64×32 load at `PIX_W`=8 → 512 writes at addresses 0..511, all byte_en=1111, `loaded` set; then START 32'h80000000 → `start`=1; then `done` pulse → `start`=0.
- 3×3 image → 3 writes; last write byte_en=0001. With `PIX_W`=16 → 5 writes; last write byte_en=0011.
- Width=0, or START before load completes → `error`=1, config outputs unchanged, `start`=0.
- Simultaneous `ir_in` edges with `i_mem_rdata`=32'hDEADBEEF → the write occurs first; `response_valid` pulses one cycle later than the solo case, with `response_data`=32'hDEADBEEF.
- `reset` asserted after 100 data words → all outputs 0 and state IDLE; a following CONFIG and load restarts at address `BASE_ADDR`.
